// File: rtl/cim_inst_encoder.sv
// Expands one field-level CIM request into count+1 packed instruction words and
// streams them through a small FWFT FIFO. Optional macro: CIM_ENC_ADDR_CHECK_EN.
module cim_inst_encoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int OP_W       = 8,
    parameter int ADDR_W     = 8,
    parameter int INST_W     = OP_W + 3 * ADDR_W,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [ADDR_W-1:0] req_s1,
    input  logic [ADDR_W-1:0] req_s2,
    input  logic [ADDR_W-1:0] req_d1,
    input  logic [ADDR_W-1:0] req_count,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_word,
    output logic              busy,
    output logic [CNT_W-1:0]  issued_cnt,
    output logic              err_ovf
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic {
        IDLE,
        EXPAND
    } state_t;

    state_t              state_reg, state_next;
    logic [OP_W-1:0]     op_reg, op_next;
    logic [ADDR_W-1:0]   s1_reg, s1_next;
    logic [ADDR_W-1:0]   s2_reg, s2_next;
    logic [ADDR_W-1:0]   d1_reg, d1_next;
    logic [ADDR_W-1:0]   rem_reg, rem_next;

    logic [INST_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]      occ_reg;
    logic [CNT_W-1:0]    issued_cnt_reg;

    logic                accept;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;
    logic                addr_ovf;

    assign empty      = (occ_reg == '0);
    assign full       = (occ_reg == (PTR_W + 1)'(FIFO_DEPTH));
    assign pop        = !empty && inst_ready;
    assign req_ready  = rst_n && (state_reg == IDLE);
    assign accept     = req_valid && req_ready;
    assign inst_valid = !empty;
    // Head entry is exposed directly; an empty FIFO shows zero rather than stale data.
    assign inst_word  = empty ? '0 : fifo_mem[rd_ptr_reg];
    assign busy       = (state_reg == EXPAND) || !empty;
    assign issued_cnt = issued_cnt_reg;

`ifdef CIM_ENC_ADDR_CHECK_EN
    logic [2:0]          ovf_bits;
    logic [ADDR_W-1:0]   base_addr [3];
    logic                err_ovf_reg;

    assign base_addr[0] = req_s1;
    assign base_addr[1] = req_s2;
    assign base_addr[2] = req_d1;

    // Carry out of the (ADDR_W+1)-bit sum means the last word would run past the top.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_ovf
            logic [ADDR_W:0] end_addr;
            assign end_addr     = {1'b0, base_addr[gi]} + {1'b0, req_count};
            assign ovf_bits[gi] = end_addr[ADDR_W];
        end
    endgenerate

    assign addr_ovf = |ovf_bits;
    assign err_ovf  = err_ovf_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_ovf_reg <= 1'b0;
        end else if (accept && addr_ovf) begin
            err_ovf_reg <= 1'b1;
        end
    end
`else
    assign addr_ovf = 1'b0;
    assign err_ovf  = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        s1_next    = s1_reg;
        s2_next    = s2_reg;
        d1_next    = d1_reg;
        rem_next   = rem_reg;
        push       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept && !addr_ovf) begin
                    op_next    = req_op;
                    s1_next    = req_s1;
                    s2_next    = req_s2;
                    d1_next    = req_d1;
                    rem_next   = req_count;
                    state_next = EXPAND;
                end
            end
            EXPAND: begin
                // A pop on the same edge frees the slot being written.
                if (!full || pop) begin
                    push    = 1'b1;
                    s1_next = s1_reg + 1'b1;
                    s2_next = s2_reg + 1'b1;
                    d1_next = d1_reg + 1'b1;
                    if (rem_reg == '0) begin
                        state_next = IDLE;
                    end else begin
                        rem_next = rem_reg - 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            op_reg    <= '0;
            s1_reg    <= '0;
            s2_reg    <= '0;
            d1_reg    <= '0;
            rem_reg   <= '0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            s1_reg    <= s1_next;
            s2_reg    <= s2_next;
            d1_reg    <= d1_next;
            rem_reg   <= rem_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {op_reg, s1_reg, s2_reg, d1_reg};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            occ_reg        <= '0;
            issued_cnt_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg     <= rd_ptr_reg + 1'b1;
                issued_cnt_reg <= issued_cnt_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ_reg <= occ_reg + 1'b1;
                2'b01:   occ_reg <= occ_reg - 1'b1;
                default: occ_reg <= occ_reg;
            endcase
        end
    end

endmodule

// File: tb/tb_cim_inst_encoder.sv
// Randomised bench for cim_inst_encoder: a queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expected words.
module tb_cim_inst_encoder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_op = '0;
    logic [7:0]  req_s1 = '0;
    logic [7:0]  req_s2 = '0;
    logic [7:0]  req_d1 = '0;
    logic [7:0]  req_count = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_word;
    logic        busy;
    logic [15:0] issued_cnt;
    logic        err_ovf;

    cim_inst_encoder #(
        .FIFO_DEPTH(DEPTH),
        .OP_W(8),
        .ADDR_W(8),
        .INST_W(32),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op(req_op),
        .req_s1(req_s1),
        .req_s2(req_s2),
        .req_d1(req_d1),
        .req_count(req_count),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst_word(inst_word),
        .busy(busy),
        .issued_cnt(issued_cnt),
        .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: words queued for output, words still to be generated.
    logic [31:0] m_fifo[$];
    int          m_left = 0;
    logic [7:0]  m_op, m_s1, m_s2, m_d1;
    logic [15:0] m_issued = '0;
    logic        m_err = 1'b0;
    bit          model_ok = 1'b0;
    bit          rand_mode = 1'b0;
    logic [31:0] obs_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Compare on the falling edge, advance the model on the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (model_ok) begin
                chk("inst_valid", inst_valid, (m_fifo.size() > 0));
                chk("inst_word", inst_word, (m_fifo.size() > 0) ? m_fifo[0] : 32'h0);
                chk("req_ready", req_ready, (rst_n && m_left == 0));
                chk("busy", busy, (m_left > 0 || m_fifo.size() > 0));
                chk("issued_cnt", issued_cnt, m_issued);
                chk("err_ovf", err_ovf, m_err);
                if (inst_valid && inst_ready) obs_q.push_back(inst_word);
            end
            @(posedge clk);
            if (!rst_n) begin
                m_fifo.delete();
                m_left   = 0;
                m_issued = '0;
                m_err    = 1'b0;
                model_ok = 1'b1;
            end else if (model_ok) begin
                bit do_pop, do_push, do_acc;
                do_pop  = (m_fifo.size() > 0) && inst_ready;
                do_push = (m_left > 0) && ((m_fifo.size() < DEPTH) || do_pop);
                do_acc  = req_valid && (m_left == 0);
                if (do_pop) begin
                    void'(m_fifo.pop_front());
                    m_issued = m_issued + 16'd1;
                end
                if (do_push) begin
                    m_fifo.push_back({m_op, m_s1, m_s2, m_d1});
                    m_s1 = m_s1 + 8'd1;
                    m_s2 = m_s2 + 8'd1;
                    m_d1 = m_d1 + 8'd1;
                    m_left--;
                end
                if (do_acc) begin
                    bit ovf;
                    ovf = 1'b0;
`ifdef CIM_ENC_ADDR_CHECK_EN
                    ovf = (int'(req_s1) + int'(req_count) > 255) ||
                          (int'(req_s2) + int'(req_count) > 255) ||
                          (int'(req_d1) + int'(req_count) > 255);
`endif
                    if (ovf) begin
                        m_err = 1'b1;
                    end else begin
                        m_op   = req_op;
                        m_s1   = req_s1;
                        m_s2   = req_s2;
                        m_d1   = req_d1;
                        m_left = int'(req_count) + 1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_mode) inst_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] op, input logic [7:0] s1, input logic [7:0] s2,
                        input logic [7:0] d1, input logic [7:0] cnt);
        bit ok;
        ok        = 1'b0;
        req_op    = op;
        req_s1    = s1;
        req_s2    = s2;
        req_d1    = d1;
        req_count = cnt;
        req_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL req_accept_timeout actual=0 required=1 t=%0t", $time);
        end else begin
            $display("REQ op=%02h s1=%02h s2=%02h d1=%02h count=%0d", op, s1, s2, d1, cnt);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            step(1);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL idle_timeout actual=busy required=idle t=%0t", $time);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(1);
        chk("reset_issued", issued_cnt, 16'd0);
        chk("reset_ready", req_ready, 1'b1);

        // Single word.
        inst_ready = 1'b1;
        obs_q.delete();
        send(8'h01, 8'h10, 8'h20, 8'h30, 8'd0);
        wait_idle();
        chk("single_n", obs_q.size(), 1);
        if (obs_q.size() >= 1) chk("single_w0", obs_q[0], 32'h01102030);
        chk("single_issued", issued_cnt, 16'd1);

        // Burst of four.
        obs_q.delete();
        send(8'h01, 8'h10, 8'h20, 8'h30, 8'd3);
        wait_idle();
        chk("burst_n", obs_q.size(), 4);
        if (obs_q.size() >= 4) begin
            chk("burst_w0", obs_q[0], 32'h01102030);
            chk("burst_w1", obs_q[1], 32'h01112131);
            chk("burst_w2", obs_q[2], 32'h01122232);
            chk("burst_w3", obs_q[3], 32'h01132333);
        end
        chk("burst_issued", issued_cnt, 16'd5);

        // Backpressure: FIFO fills, expansion stalls, head word holds.
        inst_ready = 1'b0;
        obs_q.delete();
        send(8'h01, 8'h10, 8'h20, 8'h30, 8'd7);
        step(10);
        chk("bp_word", inst_word, 32'h01102030);
        chk("bp_valid", inst_valid, 1'b1);
        chk("bp_busy", busy, 1'b1);
        chk("bp_ready", req_ready, 1'b0);
        inst_ready = 1'b1;
        wait_idle();
        chk("bp_n", obs_q.size(), 8);
        if (obs_q.size() >= 8) chk("bp_w7", obs_q[7], 32'h01172737);

        // Address wrap at the top of the space.
        obs_q.delete();
        send(8'h02, 8'h00, 8'h00, 8'hFE, 8'd2);
        wait_idle();
        step(1);
`ifdef CIM_ENC_ADDR_CHECK_EN
        chk("wrap_n", obs_q.size(), 0);
        chk("wrap_err", err_ovf, 1'b1);
`else
        chk("wrap_n", obs_q.size(), 3);
        if (obs_q.size() >= 3) begin
            chk("wrap_d0", obs_q[0], 32'h020000FE);
            chk("wrap_d1", obs_q[1], 32'h020101FF);
            chk("wrap_d2", obs_q[2], 32'h02020200);
        end
        chk("wrap_err", err_ovf, 1'b0);
`endif

        // Reset in the middle of a burst.
        inst_ready = 1'b0;
        send(8'h03, 8'h40, 8'h50, 8'h60, 8'd7);
        step(3);
        rst_n = 1'b0;
        step(1);
        chk("rst_valid", inst_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_issued", issued_cnt, 16'd0);
        chk("rst_ready_low", req_ready, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready_high", req_ready, 1'b1);
        step(1);

        // Random traffic with random backpressure.
        rand_mode = 1'b1;
        for (int n = 0; n < 300; n++) begin
            logic [7:0] c;
            step($urandom_range(0, 3));
            c = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(10, 40)) : 8'($urandom_range(0, 9));
            send(8'($urandom), 8'($urandom), 8'($urandom_range(0, 200)), 8'($urandom), c);
        end
        rand_mode = 1'b0;
        step(1);
        inst_ready = 1'b1;
        wait_idle();
        chk("final_drained", m_fifo.size() + m_left, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
